alu: RTL and testbench

// - Registered 8-bit arithmetic/logic unit: 16 operations selected by ALU_Sel, one result byte + carry flag.
// - General-purpose datapath block; operands come from registers or the bus; the result is registered for timing.
// - Single clock domain; one new operation may be issued every cycle.

---
 rtl/alu.sv | 138 +++++++++++++
 tb/tb_alu.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/alu.sv
// Registered 8-bit ALU: 16 ops on unsigned A/B, result byte plus carry/status flag.
// Latency 1: operands sampled on rising edge N, result valid after edge N until edge N+1.
// No backpressure: accepts a new operation every cycle, every non-reset edge reloads outputs.
//
// Ports:
//   clock    - single clock, all state updates on rising edge
//   reset    - synchronous active-high, highest priority
//   A, B     - unsigned operands (WIDTH bits)
//   ALU_Sel  - operation select (see op_e)
//   ALU_Out  - registered result
//   CarryOut - registered carry / borrow / overflow / divide-by-zero flag
//   Zero     - registered "result is zero" flag, present only when ALU_ZERO_FLAG_EN is defined

module alu #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       ALU_Sel,
    output logic [WIDTH-1:0] ALU_Out,
`ifdef ALU_ZERO_FLAG_EN
    output logic             Zero,
`endif
    output logic             CarryOut
);

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0,
        OP_SUB  = 4'h1,
        OP_MUL  = 4'h2,
        OP_DIV  = 4'h3,
        OP_SHL  = 4'h4,
        OP_SHR  = 4'h5,
        OP_ROL  = 4'h6,
        OP_ROR  = 4'h7,
        OP_AND  = 4'h8,
        OP_OR   = 4'h9,
        OP_XOR  = 4'hA,
        OP_NOR  = 4'hB,
        OP_NAND = 4'hC,
        OP_XNOR = 4'hD,
        OP_GT   = 4'hE,
        OP_EQ   = 4'hF
    } op_e;

    logic [WIDTH-1:0]   alu_out_d, alu_out_q;
    logic               carry_d,   carry_q;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quot;
    op_e                op;

    assign op = op_e'(ALU_Sel);

    // Wide intermediates so carry/overflow information is not lost to truncation.
    assign sum  = {1'b0, A} + {1'b0, B};
    assign prod = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};
    // Divider is guarded so B==0 never reaches the division operator.
    assign quot = (B == '0) ? '1 : (A / B);

    always_comb begin
        alu_out_d = '0;
        carry_d   = 1'b0;
        case (op)
            OP_ADD: begin
                alu_out_d = sum[WIDTH-1:0];
                carry_d   = sum[WIDTH];
            end
            OP_SUB: begin
                alu_out_d = A - B;
                carry_d   = (A < B);
            end
            OP_MUL: begin
                alu_out_d = prod[WIDTH-1:0];
                carry_d   = |prod[2*WIDTH-1:WIDTH];
            end
            OP_DIV: begin
                alu_out_d = quot;
                carry_d   = (B == '0);
            end
            OP_SHL: begin
                alu_out_d = {A[WIDTH-2:0], 1'b0};
                carry_d   = A[WIDTH-1];
            end
            OP_SHR: begin
                alu_out_d = {1'b0, A[WIDTH-1:1]};
                carry_d   = A[0];
            end
            OP_ROL:  alu_out_d = {A[WIDTH-2:0], A[WIDTH-1]};
            OP_ROR:  alu_out_d = {A[0], A[WIDTH-1:1]};
            OP_AND:  alu_out_d = A & B;
            OP_OR:   alu_out_d = A | B;
            OP_XOR:  alu_out_d = A ^ B;
            OP_NOR:  alu_out_d = ~(A | B);
            OP_NAND: alu_out_d = ~(A & B);
            OP_XNOR: alu_out_d = ~(A ^ B);
            OP_GT:   alu_out_d = {{(WIDTH-1){1'b0}}, (A > B)};
            OP_EQ:   alu_out_d = {{(WIDTH-1){1'b0}}, (A == B)};
            default: begin
                alu_out_d = '0;
                carry_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            alu_out_q <= '0;
            carry_q   <= 1'b0;
        end else begin
            alu_out_q <= alu_out_d;
            carry_q   <= carry_d;
        end
    end

    assign ALU_Out  = alu_out_q;
    assign CarryOut = carry_q;

`ifdef ALU_ZERO_FLAG_EN
    logic zero_d, zero_q;

    // Computed from the next result so it lines up with ALU_Out in the same cycle.
    assign zero_d = (alu_out_d == '0);

    always_ff @(posedge clock) begin
        if (reset) begin
            zero_q <= 1'b1;
        end else begin
            zero_q <= zero_d;
        end
    end

    assign Zero = zero_q;
`endif

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed vector table plus reset/back-to-back sequences.
// Inputs driven on the falling edge, outputs sampled 1ns after the following rising edge.
// Prints one summary line and finishes; a watchdog bounds total runtime.

module tb_alu;

    localparam int W = 8;

    logic         clock;
    logic         reset;
    logic [W-1:0] A, B;
    logic [3:0]   ALU_Sel;
    logic [W-1:0] ALU_Out;
    logic         CarryOut;
`ifdef ALU_ZERO_FLAG_EN
    logic         Zero;
`endif

    int checks   = 0;
    int failures = 0;

    alu #(.WIDTH(W)) dut (
        .clock    (clock),
        .reset    (reset),
        .A        (A),
        .B        (B),
        .ALU_Sel  (ALU_Sel),
        .ALU_Out  (ALU_Out),
`ifdef ALU_ZERO_FLAG_EN
        .Zero     (Zero),
`endif
        .CarryOut (CarryOut)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [3:0]   sel;
        logic [W-1:0] exp_out;
        logic         exp_c;
    } vec_t;

    localparam int NVEC = 29;
    vec_t vecs [NVEC];

    task automatic check8(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic check_outs(input string name, input logic [W-1:0] exp_out, input logic exp_c);
        check8({name, ".out"}, ALU_Out, exp_out);
        check1({name, ".carry"}, CarryOut, exp_c);
`ifdef ALU_ZERO_FLAG_EN
        check1({name, ".zero"}, Zero, (exp_out == '0));
`endif
    endtask

    // Present operands on the falling edge, let one rising edge pass, sample 1ns later.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] sel);
        @(negedge clock);
        A       = a;
        B       = b;
        ALU_Sel = sel;
        @(posedge clock);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin
        //           a       b       sel    out     c
        vecs[0]  = '{8'd10,  8'd5,   4'h0, 8'd15,  1'b0};
        vecs[1]  = '{8'd20,  8'd15,  4'h0, 8'd35,  1'b0};
        vecs[2]  = '{8'd200, 8'd100, 4'h0, 8'd44,  1'b1};
        vecs[3]  = '{8'd15,  8'd5,   4'h1, 8'd10,  1'b0};
        vecs[4]  = '{8'd50,  8'd30,  4'h1, 8'd20,  1'b0};
        vecs[5]  = '{8'd5,   8'd10,  4'h1, 8'd251, 1'b1};
        vecs[6]  = '{8'd3,   8'd2,   4'h2, 8'd6,   1'b0};
        vecs[7]  = '{8'd4,   8'd5,   4'h2, 8'd20,  1'b0};
        vecs[8]  = '{8'd20,  8'd20,  4'h2, 8'd144, 1'b1};
        vecs[9]  = '{8'd20,  8'd4,   4'h3, 8'd5,   1'b0};
        vecs[10] = '{8'd30,  8'd5,   4'h3, 8'd6,   1'b0};
        vecs[11] = '{8'd7,   8'd0,   4'h3, 8'd255, 1'b1};
        vecs[12] = '{8'hA5,  8'h0F,  4'h4, 8'h4A,  1'b1};
        vecs[13] = '{8'hA5,  8'h0F,  4'h5, 8'h52,  1'b1};
        vecs[14] = '{8'hA5,  8'h0F,  4'h6, 8'h4B,  1'b0};
        vecs[15] = '{8'hA5,  8'h0F,  4'h7, 8'hD2,  1'b0};
        vecs[16] = '{8'hA5,  8'h0F,  4'h8, 8'h05,  1'b0};
        vecs[17] = '{8'hA5,  8'h0F,  4'h9, 8'hAF,  1'b0};
        vecs[18] = '{8'hA5,  8'h0F,  4'hA, 8'hAA,  1'b0};
        vecs[19] = '{8'hA5,  8'h0F,  4'hB, 8'h50,  1'b0};
        vecs[20] = '{8'hA5,  8'h0F,  4'hC, 8'hFA,  1'b0};
        vecs[21] = '{8'hA5,  8'h0F,  4'hD, 8'h55,  1'b0};
        vecs[22] = '{8'hA5,  8'h0F,  4'hE, 8'h01,  1'b0};
        vecs[23] = '{8'hA5,  8'h0F,  4'hF, 8'h00,  1'b0};
        vecs[24] = '{8'd255, 8'd1,   4'h0, 8'd0,   1'b1};
        vecs[25] = '{8'd0,   8'd1,   4'h1, 8'd255, 1'b1};
        vecs[26] = '{8'd16,  8'd16,  4'h2, 8'd0,   1'b1};
        vecs[27] = '{8'd255, 8'd255, 4'h3, 8'd1,   1'b0};
        vecs[28] = '{8'd0,   8'd0,   4'h3, 8'd255, 1'b1};

        // Reset for one cycle with a live ADD on the inputs; reset must win.
        reset   = 1'b1;
        A       = 8'd200;
        B       = 8'd100;
        ALU_Sel = 4'h0;
        @(posedge clock);
        #1;
        check_outs("reset", 8'd0, 1'b0);
        @(negedge clock);
        reset = 1'b0;
        // Released but no rising edge yet: reset values must still be held.
        #1;
        check_outs("post_reset_hold", 8'd0, 1'b0);

        for (int i = 0; i < NVEC; i++) begin
            issue(vecs[i].a, vecs[i].b, vecs[i].sel);
            check_outs($sformatf("vec%0d", i), vecs[i].exp_out, vecs[i].exp_c);
        end

        // Back-to-back issue: each edge loads a fresh result, no stale carry.
        issue(8'd200, 8'd100, 4'h0);
        check_outs("b2b_add", 8'd44, 1'b1);
        issue(8'hF0, 8'h0F, 4'hB);
        check_outs("b2b_nor", 8'h00, 1'b0);
        issue(8'd9, 8'd9, 4'hF);
        check_outs("b2b_eq", 8'd1, 1'b0);

        // Reset mid-stream discards the in-flight operation.
        issue(8'd5, 8'd10, 4'h1);
        check_outs("pre_mid_reset", 8'd251, 1'b1);
        @(negedge clock);
        A       = 8'd255;
        B       = 8'd1;
        ALU_Sel = 4'h0;
        reset   = 1'b1;
        @(posedge clock);
        #1;
        check_outs("mid_reset", 8'd0, 1'b0);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        check_outs("after_mid_reset", 8'd0, 1'b1);

        // Inputs wiggling between edges must not matter; only edge values count.
        @(negedge clock);
        A       = 8'd1;
        B       = 8'd2;
        ALU_Sel = 4'h0;
        #2;
        A       = 8'd100;
        B       = 8'd3;
        ALU_Sel = 4'h2;
        @(posedge clock);
        #1;
        check_outs("edge_sampled", 8'd44, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
